wb_lsu_master: RTL

Wishbone B4 classic-cycle master that turns single core load/store requests into one bus transaction each. It sits between the core memory stage and the data-side Wishbone interconnect, which feeds the data memory and peripheral slaves. The block generates byte selects and replicated write-data lanes. It aligns and sign/zero-extends read data. It reports misalignment, bus error and timeout as a single error response.

---
 rtl/wb_lsu_master.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic-cycle load/store master: one bus transaction per core request,
// with lane steering, load extension and a single error response path.
module wb_lsu_master #(
    parameter int unsigned READ_DELAY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic               err_q, err_d;
    logic [31:0]        rword_q, rword_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ready_q, ready_d;
    logic               cyc_q, cyc_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        adr_q, adr_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        dat_q, dat_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rerr_q, rerr_d;

    // Size 3 is never legal; half and word must be naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            2'd2:    is_misaligned = |off;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_sel = 4'b0001 << off;
            2'd1:    lane_sel = off[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    lane_wdata = {4{wdata[7:0]}};
            2'd1:    lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            off_q    <= 2'd0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            rword_q  <= 32'd0;
            tmo_q    <= '0;
            ready_q  <= 1'b1;
            cyc_q    <= 1'b0;
            bus_we_q <= 1'b0;
            adr_q    <= 32'd0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            rword_q  <= rword_d;
            tmo_q    <= tmo_d;
            ready_q  <= ready_d;
            cyc_q    <= cyc_d;
            bus_we_q <= bus_we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        err_d    = err_q;
        rword_d  = rword_q;
        tmo_d    = tmo_q;
        cyc_d    = cyc_q;
        bus_we_d = bus_we_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d   = req_we_i;
                    off_d  = req_addr_i[1:0];
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
                    if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d    = 1'b0;
                        tmo_d    = '0;
                        cyc_d    = 1'b1;
                        bus_we_d = req_we_i;
                        adr_d    = {req_addr_i[31:2], 2'b00};
                        sel_d    = lane_sel(req_size_i, req_addr_i[1:0]);
                        dat_d    = lane_wdata(req_size_i, req_wdata_i);
                        state_d  = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // err_i wins over a simultaneous ack_i
                if (err_i) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end else if (ack_i) begin
                    cyc_d = 1'b0;
                    if (we_q) begin
                        state_d = RESP;
                    end else if (READ_DELAY == 0) begin
                        rword_d = dat_i;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DATA: begin
                rword_d = dat_i;
                state_d = RESP;
            end
            RESP: begin
                rvalid_d = 1'b1;
                rerr_d   = err_q;
                rdata_d  = (err_q || we_q) ? 32'd0 : load_extend(rword_q, off_q, size_q, uns_q);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign req_ready_o  = ready_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = bus_we_q;
    assign adr_o        = adr_q;
    assign sel_o        = sel_q;
    assign dat_o        = dat_q;
    assign resp_valid_o = rvalid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = rerr_q;

endmodule
